// File: rtl/fir_out_serializer.sv
// fir_out_serializer
//   Sits behind the 3-parallel FIR_Filter. Each VIN-qualified triple
//   (DIN0 oldest .. DIN2 newest) is stored in a DEPTH-entry triple FIFO.
//   The block then replays the samples one per accepted handshake
//   (VOUT/READY_I), lane 0 first. A triple that arrives while the FIFO
//   is full and no pop happens on that edge is dropped, and OVF is set.
//
// Ports
//   CLK, RST_n        clock (rising edge), asynchronous active-low reset
//   VIN, DIN0..DIN2   input triple and its valid strobe (no back-pressure)
//   READY_I           downstream ready
//   VOUT, DOUT        serialized output sample and its valid
//   FULL              FIFO holds DEPTH triples (registered)
//   OVF               sticky drop flag
//   OVF_CNT           saturating 8-bit drop counter, present only when
//                     FIR_SER_OVF_CNT_EN is defined (OVF = OVF_CNT != 0)
module fir_out_serializer #(
  parameter int unsigned DW    = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic          VIN,
  input  logic [DW-1:0] DIN0,
  input  logic [DW-1:0] DIN1,
  input  logic [DW-1:0] DIN2,
  input  logic          READY_I,
  output logic          VOUT,
  output logic [DW-1:0] DOUT,
  output logic          FULL,
  output logic          OVF
`ifdef FIR_SER_OVF_CNT_EN
  ,
  output logic [7:0]    OVF_CNT
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {ST_EMPTY, ST_VALID} state_e;
  typedef logic [3*DW-1:0] triple_t;

  triple_t       mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_e        state_q, state_d;
  logic [1:0]    lane_q, lane_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          full_q;
  logic          xfer, pop, push, drop;
  triple_t       head, next_head;

  function automatic logic [DW-1:0] lane_sel(input triple_t t, input logic [1:0] l);
    logic [DW-1:0] r;
    case (l)
      2'd0:    r = t[DW-1:0];
      2'd1:    r = t[2*DW-1:DW];
      default: r = t[3*DW-1:2*DW];
    endcase
    return r;
  endfunction

  always_comb begin
    head      = mem_q[rd_ptr_q];
    next_head = mem_q[rd_ptr_q + AW'(1)];
    xfer      = (state_q == ST_VALID) && READY_I;
    // The head triple leaves the FIFO only when its last lane transfers.
    pop       = xfer && (lane_q == 2'd2);
    push      = VIN && ((count_q != DEPTH_C) || pop);
    drop      = VIN && !push;

    state_d = state_q;
    lane_d  = lane_q;
    dout_d  = dout_q;
    case (state_q)
      ST_EMPTY: begin
        if (count_q != '0) begin
          dout_d  = lane_sel(head, lane_q);
          state_d = ST_VALID;
        end
      end
      default: begin
        if (xfer) begin
          if (lane_q != 2'd2) begin
            lane_d = lane_q + 2'd1;
            dout_d = lane_sel(head, lane_q + 2'd1);
          end else begin
            lane_d = '0;
            // Back-to-back only from a triple already stored; a triple
            // written on this same edge is picked up from EMPTY next edge.
            if (count_q > CW'(1)) begin
              dout_d = lane_sel(next_head, 2'd0);
            end else begin
              state_d = ST_EMPTY;
            end
          end
        end
      end
    endcase

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // A push at full overwrites the head slot only on the edge the head pops.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {DIN2, DIN1, DIN0};
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q  <= ST_EMPTY;
      lane_q   <= '0;
      dout_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      dout_q   <= dout_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
    end
  end

  assign VOUT = (state_q == ST_VALID);
  assign DOUT = dout_q;
  assign FULL = full_q;

`ifdef FIR_SER_OVF_CNT_EN
  logic [7:0] ovf_cnt_q;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      ovf_cnt_q <= '0;
    end else if (drop && (ovf_cnt_q != '1)) begin
      ovf_cnt_q <= ovf_cnt_q + 8'd1;
    end
  end

  assign OVF_CNT = ovf_cnt_q;
  assign OVF     = (ovf_cnt_q != '0);
`else
  logic ovf_q;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end
  end

  assign OVF = ovf_q;
`endif

endmodule

// File: tb/tb_fir_out_serializer.sv
module tb_fir_out_serializer;
  localparam int unsigned DW    = 12;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vin;
  logic          ready;
  logic [DW-1:0] din0, din1, din2;
  logic          vout;
  logic [DW-1:0] dout;
  logic          full;
  logic          ovf;
`ifdef FIR_SER_OVF_CNT_EN
  logic [7:0]    ovf_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic [DW-1:0] d0, d1, d2;
    logic [DW-1:0] e0, e1, e2;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  fir_out_serializer #(.DW(DW), .DEPTH(DEPTH)) dut (
    .CLK(clk), .RST_n(rst_n), .VIN(vin),
    .DIN0(din0), .DIN1(din1), .DIN2(din2),
    .READY_I(ready), .VOUT(vout), .DOUT(dout),
    .FULL(full), .OVF(ovf)
`ifdef FIR_SER_OVF_CNT_EN
    , .OVF_CNT(ovf_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: a transfer happens at the next rising edge when VOUT and
  // READY_I are both high; inputs only change just after rising edges.
  always @(negedge clk) begin
    if (rst_n && vout && ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_extra: got 0x%0h expected no sample", dout);
      end else begin
        check("sb_dout", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [DW-1:0] c, input bit accept);
    vin  = 1'b1;
    din0 = a;
    din1 = b;
    din2 = c;
    if (accept) begin
      exp_q.push_back(a);
      exp_q.push_back(b);
      exp_q.push_back(c);
    end
    step(1);
    vin = 1'b0;
  endtask

  task automatic drain(input string name);
    int unsigned k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      step(1);
      k++;
    end
    check({name, "_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_vout_end"}, 32'(vout), 32'd0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    vin = 1'b0;
    exp_q.delete();
    step(2);
    #2 rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    vin   = 1'b0;
    ready = 1'b1;
    din0  = '0;
    din1  = '0;
    din2  = '0;

    tbl[0] = '{12'h800, 12'hFFF, 12'h000, 12'h800, 12'hFFF, 12'h000};
    tbl[1] = '{12'h7FF, 12'h001, 12'h555, 12'h7FF, 12'h001, 12'h555};
    tbl[2] = '{12'hAAA, 12'h123, 12'hFED, 12'hAAA, 12'h123, 12'hFED};
    tbl[3] = '{12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000};
    tbl[4] = '{12'hFFF, 12'h800, 12'h7FF, 12'hFFF, 12'h800, 12'h7FF};
    tbl[5] = '{12'h3C3, 12'hC3C, 12'h0F0, 12'h3C3, 12'hC3C, 12'h0F0};

    // Reset state
    #12;
    check("rst_vout", 32'(vout), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    #1 rst_n = 1'b1;
    step(1);

    // Single triple: latency n+2 .. n+4, idle in n+5
    ready = 1'b1;
    push(12'd5, 12'hFFD, 12'h7FF, 1'b1);
    check("lat_n1_vout", 32'(vout), 32'd0);
    step(1);
    check("lat_n2_vout", 32'(vout), 32'd1);
    check("lat_n2_dout", 32'(dout), 32'd5);
    step(1);
    check("lat_n3_dout", 32'(dout), 32'hFFD);
    step(1);
    check("lat_n4_dout", 32'(dout), 32'h7FF);
    step(1);
    check("lat_n5_vout", 32'(vout), 32'd0);
    check("lat_left", 32'(exp_q.size()), 32'd0);

    // Stall holds the first sample
    ready = 1'b0;
    push(12'd5, 12'hFFD, 12'h7FF, 1'b1);
    step(1);
    for (int i = 0; i < 5; i++) begin
      check("stall_vout", 32'(vout), 32'd1);
      check("stall_dout", 32'(dout), 32'd5);
      step(1);
    end
    ready = 1'b1;
    drain("stall");

    // Fill, overflow drop, drain
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(12'(3*i+1), 12'(3*i+2), 12'(3*i+3), 1'b1);
    end
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_pre",  32'(ovf),  32'd0);
    push(12'd13, 12'd14, 12'd15, 1'b0);
    check("ovf_set",   32'(ovf),  32'd1);
    check("ovf_full2", 32'(full), 32'd1);
    ready = 1'b1;
    drain("ovf");
    check("ovf_sticky", 32'(ovf), 32'd1);
    check("ovf_full_end", 32'(full), 32'd0);

    // Async reset after the lane-1 transfer (OVF still set from above)
    ready = 1'b1;
    push(12'd100, 12'd200, 12'd300, 1'b1);
    step(1);
    check("mid_dout0", 32'(dout), 32'd100);
    step(2);
    check("mid_dout2", 32'(dout), 32'd300);
    check("mid_ovf", 32'(ovf), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_vout", 32'(vout), 32'd0);
    check("mid_rst_dout", 32'(dout), 32'd0);
    check("mid_rst_full", 32'(full), 32'd0);
    check("mid_rst_ovf",  32'(ovf),  32'd0);
    exp_q.delete();
    step(2);
    #2 rst_n = 1'b1;
    step(1);
    push(12'd7, 12'd8, 12'd9, 1'b1);
    check("mid_new_n1", 32'(vout), 32'd0);
    step(1);
    check("mid_new_dout", 32'(dout), 32'd7);
    drain("mid_new");

    // Push at full on the same edge as a lane-2 pop
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(12'(20+3*i), 12'(21+3*i), 12'(22+3*i), 1'b1);
    end
    check("fp_full", 32'(full), 32'd1);
    ready = 1'b1;
    step(2);
    push(12'd40, 12'd41, 12'd42, 1'b1);
    check("fp_full_kept", 32'(full), 32'd1);
    check("fp_no_ovf",    32'(ovf),  32'd0);
    drain("fp");

    // Table vectors, one triple every third cycle
    do_reset();
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vin  = 1'b1;
      din0 = tbl[i].d0;
      din1 = tbl[i].d1;
      din2 = tbl[i].d2;
      exp_q.push_back(tbl[i].e0);
      exp_q.push_back(tbl[i].e1);
      exp_q.push_back(tbl[i].e2);
      step(1);
      vin = 1'b0;
      step(2);
    end
    drain("tbl");

    // Ramp at 1/3 duty: continuous output after fill, crossing the sign boundary
    do_reset();
    ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      for (int ph = 0; ph < 3; ph++) begin
        if (ph == 0) begin
          vin  = 1'b1;
          din0 = 12'(2000 + 3*k);
          din1 = 12'(2001 + 3*k);
          din2 = 12'(2002 + 3*k);
          exp_q.push_back(din0);
          exp_q.push_back(din1);
          exp_q.push_back(din2);
        end else begin
          vin = 1'b0;
        end
        step(1);
        if (3*k + ph >= 1) check("ramp_vout", 32'(vout), 32'd1);
      end
    end
    vin = 1'b0;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
      check("ramp_tail_vout", 32'(vout), 32'd1);
      step(1);
    end
    drain("ramp");
    check("ramp_ovf", 32'(ovf), 32'd0);

`ifdef FIR_SER_OVF_CNT_EN
    // Drop counter saturation
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(12'(50+3*i), 12'(51+3*i), 12'(52+3*i), 1'b1);
    end
    check("cnt_zero", 32'(ovf_cnt), 32'd0);
    push(12'd1, 12'd2, 12'd3, 1'b0);
    check("cnt_one", 32'(ovf_cnt), 32'd1);
    for (int i = 0; i < 299; i++) begin
      push(12'd1, 12'd2, 12'd3, 1'b0);
    end
    check("cnt_sat", 32'(ovf_cnt), 32'd255);
    check("cnt_ovf", 32'(ovf), 32'd1);
    ready = 1'b1;
    drain("cnt");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_out_serializer.md
Name: fir_out_serializer

Overview:
- Downstream neighbour of the 3-parallel unfolded pipelined FIR_Filter.
- Captures each output triple (DOUT0, DOUT1, DOUT2, qualified by VOUT) into a small triple FIFO.
- Re-emits the samples as a single-lane stream in time order (lane 0, then 1, then 2), one sample per accepted handshake, with downstream back-pressure.
- Drops triples on overflow and flags it; this decouples the 3-sample/cycle filter from a 1-sample/cycle sink.

Parameters:
- DW, 12, sample width in bits (signed two's complement)
- DEPTH, 4, FIFO depth in triples; power of 2, minimum 2

Ports:
- CLK  in  1  system clock, rising edge
- RST_n  in  1  asynchronous active-low reset
- VIN  in  1  triple valid; driven from FIR_Filter VOUT
- DIN0  in  DW  oldest sample of the triple, x[3k]
- DIN1  in  DW  sample x[3k+1]
- DIN2  in  DW  newest sample, x[3k+2]
- READY_I  in  1  downstream ready to take DOUT
- VOUT  out  1  DOUT valid
- DOUT  out  DW  serialized sample
- FULL  out  1  FIFO holds DEPTH triples
- OVF  out  1  sticky flag: a triple was dropped

Behaviour:
- Reset: one clock CLK; reset RST_n is asynchronous, active-low. While RST_n=0:
  - VOUT=0, DOUT=0, FULL=0, OVF=0.
  - FIFO pointers and count = 0; lane counter = 0; output register empty.
- Reset asserted mid-operation discards all buffered triples and any partially emitted triple.
- Write side:
  - At a rising edge with VIN=1, the triple is pushed if count<DEPTH, or if count=DEPTH and a pop occurs on the same edge.
  - Otherwise the triple is dropped, the FIFO is unchanged, and OVF is set to 1 (cleared only by reset).
  - No back-pressure to the FIR; the producer must keep average VIN duty ≤1/3 to avoid loss.
- Count: increments on push-only, decrements on pop-only, unchanged on push+pop. FULL = (count==DEPTH), registered from the count.
- Output stage is a single register (VOUT/DOUT) fed from the FIFO head, lane selected by lane counter L ∈ {0,1,2}.
- Output state machine:
  - EMPTY (VOUT=0): if FIFO non-empty, load DOUT = head lane L, set VOUT=1, go to VALID.
  - VALID: on a transfer (VOUT=1 and READY_I=1 at the edge), advance L. On the transfer of L=2, pop the head and set L=0.
    - If the next sample is available, reload DOUT the same edge with no bubble (full 1 sample/cycle throughput).
    - Otherwise VOUT=0 and return to EMPTY.
  - Stall: VOUT=1 and READY_I=0 holds DOUT and VOUT stable; a push may still occur.
- The head triple stays in the FIFO until its lane 2 transfers, so it counts toward FULL.
- Latency: VIN=1 in cycle n into an empty block gives VOUT=1, DOUT=DIN0 in cycle n+2 (write edge, then output load edge). With READY_I=1, DIN1 appears in n+3 and DIN2 in n+4.
- Pointers wrap modulo DEPTH. Data is passed unmodified (no width change, no rounding).
- Simultaneous events:
  - Push to an empty FIFO while the output is EMPTY: push this edge, load the output on the next edge.
  - Push at full with a concurrent lane-2 pop: accepted, FULL stays 1.

Optional Feature:
- Macro: FIR_SER_OVF_CNT_EN.
- Defined: adds output port OVF_CNT [7:0], a drop counter.
  - Increments by 1 on every dropped triple and saturates at 255.
  - Reset to 0.
  - OVF = (OVF_CNT != 0).
- Undefined: no OVF_CNT port or counter; OVF is a plain sticky bit.
- Write-side behaviour is identical in both builds.

Test Plan:
- Reset, then a single VIN pulse with DIN0=5, DIN1=-3, DIN2=2047, READY_I=1 → DOUT 5, -3, 2047 in cycles n+2, n+3, n+4 with VOUT=1; VOUT=0 in n+5.
- READY_I=0 for 5 cycles after the first sample becomes valid → DOUT holds 5 with VOUT=1. After READY_I rises, -3 and 2047 follow with no duplicates or skips.
- READY_I=0, push 4 triples (1..12) → FULL=1, OVF=0. A 5th push → dropped, OVF=1. Release READY_I → output 1..12 exactly, then VOUT=0.
- READY_I=1, VIN every 3rd cycle for 30 triples, ramp data → continuous VOUT=1 after fill, sample order matches the ramp, OVF=0.
- RST_n pulsed low asynchronously mid-triple (after the lane-1 transfer) → VOUT, DOUT, FULL, OVF go to 0 immediately. After release, a new triple 7, 8, 9 emerges starting from lane 0.
- With FIR_SER_OVF_CNT_EN, READY_I=0, FIFO full, 300 further pushes → OVF_CNT=255 and OVF=1.
